glb_block_tx: RTL

Synthesizable block-stream transmitter that drives the GLB ready/valid word interface used by the memory-core test harness. Holds NUM_BLOCKS preloaded blocks in local memory and, on `start`, sends each block as a length header word followed by that many data words. It sits upstream of a GLB read endpoint, supplying the block format (size word, then payload) that the endpoint consumes.

---
 rtl/glb_block_tx_pkg.sv | 21 ++
 rtl/glb_block_tx_mem.sv | 27 ++
 rtl/glb_block_tx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/glb_block_tx_pkg.sv
// Shared constants, state encoding and address-width helper for the GLB block-stream transmitter.
package glb_block_tx_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned MAX_BLOCKS = 4;
  localparam int unsigned BLK_W      = $clog2(MAX_BLOCKS);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_HDR_FETCH = 3'd1;
  localparam state_t ST_SEND_HDR  = 3'd2;
  localparam state_t ST_SEND_DATA = 3'd3;
  localparam state_t ST_NEXT_BLK  = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/glb_block_tx_mem.sv
// Block storage: 1R1W synchronous RAM with a registered read port and no reset.
module glb_block_tx_mem
  import glb_block_tx_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/glb_block_tx.sv
// GLB block-stream transmitter: sends each preloaded block as a size header plus payload words.
// Optional size clamp and sticky error flag enabled by GLB_BLOCK_TX_SIZE_CHECK_EN.
module glb_block_tx
  import glb_block_tx_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 1,
  parameter int unsigned DEPTH      = 1024,
  localparam int unsigned AW        = addr_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [BLK_W-1:0]  i_wr_blk,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_start,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_size_err
);

  localparam int unsigned      MW       = addr_w(NUM_BLOCKS * DEPTH);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [BLK_W:0]   NUM_BLK  = (BLK_W + 1)'(NUM_BLOCKS);

  state_t            r_state, w_state_nxt;
  logic [BLK_W-1:0]  r_blk, w_blk_nxt;
  logic [DATA_W-1:0] r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_size, w_size_nxt;
  logic              r_pend;
  logic [1:0]        r_cnt;
  logic              r_wr_ptr, r_rd_ptr;
  logic [DATA_W-1:0] r_fifo [2];

  logic              w_wr_ok, w_rd_en, w_blk_end, w_credit;
  logic              w_pop, w_push, w_fifo_pop;
  logic [2:0]        w_occ;
  logic [AW-1:0]     w_rd_idx;
  logic [MW-1:0]     w_waddr, w_raddr;
  logic [DATA_W-1:0] w_ram_q, w_rd_word;

  assign o_busy  = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_done  = (r_state == ST_DONE);
  assign w_wr_ok = i_wr_en && !o_busy && ({1'b0, i_wr_blk} < NUM_BLK);
  assign w_waddr = MW'({i_wr_blk, i_wr_addr});
  assign w_raddr = MW'({r_blk, w_rd_idx});

  glb_block_tx_mem #(
    .WORDS (NUM_BLOCKS * DEPTH),
    .AW    (MW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_wr_ok),
    .i_waddr (w_waddr),
    .i_wdata (i_wr_data),
    .i_re    (w_rd_en),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

`ifdef GLB_BLOCK_TX_SIZE_CHECK_EN
  localparam logic [DATA_W-1:0] MAX_SIZE = DATA_W'(DEPTH - 1);
  logic w_over, r_size_err;
  // The header is on the RAM output exactly while in SEND_HDR.
  assign w_over    = (r_state == ST_SEND_HDR) && (w_ram_q > MAX_SIZE);
  assign w_rd_word = w_over ? MAX_SIZE : w_ram_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    r_size_err <= 1'b0;
    else if (w_over) r_size_err <= 1'b1;
  end
  assign o_size_err = r_size_err;
`else
  assign w_rd_word  = w_ram_q;
  assign o_size_err = 1'b0;
`endif

  // Output queue = up to two skid entries followed by the in-flight RAM word.
  assign o_valid    = (r_cnt != 2'd0) || r_pend;
  assign w_pop      = o_valid && i_ready;
  assign w_fifo_pop = w_pop && (r_cnt != 2'd0);
  assign w_push     = r_pend && !(w_pop && (r_cnt == 2'd0));
  assign w_occ      = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_credit   = (w_occ <= 3'd1);

  always_comb begin
    if (r_cnt != 2'd0) o_data = r_fifo[r_rd_ptr];
    else if (r_pend)   o_data = w_rd_word;
    else               o_data = '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_blk_nxt   = r_blk;
    w_idx_nxt   = r_idx;
    w_size_nxt  = r_size;
    w_rd_en     = 1'b0;
    w_rd_idx    = '0;
    w_blk_end   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_HDR_FETCH;
          w_blk_nxt   = '0;
        end
      end
      ST_HDR_FETCH: begin
        if (w_credit) begin
          w_rd_en     = 1'b1;
          w_state_nxt = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR: begin
        w_size_nxt = w_rd_word;
        if (w_rd_word == '0) begin
          w_blk_end = 1'b1;
        end else if (w_credit) begin
          w_rd_en  = 1'b1;
          w_rd_idx = AW'(1);
          if (w_rd_word == 16'd1) begin
            w_blk_end = 1'b1;
          end else begin
            w_idx_nxt   = 16'd2;
            w_state_nxt = ST_SEND_DATA;
          end
        end else begin
          w_idx_nxt   = 16'd1;
          w_state_nxt = ST_SEND_DATA;
        end
      end
      ST_SEND_DATA: begin
        if (w_credit) begin
          w_rd_en  = 1'b1;
          w_rd_idx = r_idx[AW-1:0];
          if (r_idx == r_size) w_blk_end = 1'b1;
          else                 w_idx_nxt = r_idx + 16'd1;
        end
      end
      // Final block fully fetched: wait for the queue to drain.
      ST_NEXT_BLK: begin
        if (w_occ == 3'd0) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_blk_end) begin
      if (r_blk != LAST_BLK) begin
        w_blk_nxt   = r_blk + 1'b1;
        w_state_nxt = ST_HDR_FETCH;
      end else if (!w_rd_en && (w_occ == 3'd0)) begin
        w_state_nxt = ST_DONE;
      end else begin
        w_state_nxt = ST_NEXT_BLK;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_blk    <= '0;
      r_idx    <= '0;
      r_size   <= '0;
      r_pend   <= 1'b0;
      r_cnt    <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_blk   <= w_blk_nxt;
      r_idx   <= w_idx_nxt;
      r_size  <= w_size_nxt;
      r_pend  <= w_rd_en;
      r_cnt   <= r_cnt + {1'b0, w_push} - {1'b0, w_fifo_pop};
      if (w_push)     r_wr_ptr <= ~r_wr_ptr;
      if (w_fifo_pop) r_rd_ptr <= ~r_rd_ptr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_rd_word;
  end

endmodule
